half_vector_collector: RTL and testbench

Collects pairs of half-width element vectors from an upstream producer into one full-width vector of NO_OF_UNITS elements. It presents that full vector to the downstream stage with a valid/ready handshake. The block sits directly upstream of the N-to-2N demux stage's consumers and is the sequential counterpart of it: the first accepted half always lands in the lower half of the output, and the second in the upper half. A flush request drains a lone lower half as a partial vector.

---
 rtl/half_vector_collector.sv | 94 +++++++++
 tb/tb_half_vector_collector.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/half_vector_collector.sv
// Pairs two half-width vectors into one full-width output vector with a
// valid/ready handshake; a flush drains a lone lower half as a partial vector.
module half_vector_collector #(
   parameter int unsigned  NO_OF_UNITS   = 8,
   parameter int unsigned  ELEMENT_WIDTH = 32,
   localparam int unsigned HALF_W        = ELEMENT_WIDTH * (NO_OF_UNITS / 2),
   localparam int unsigned CNT_W         = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [HALF_W-1:0]   in_data,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                flush,
   output logic [2*HALF_W-1:0] out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_partial,
   output logic [CNT_W-1:0]    vec_count
);

   typedef enum logic {S_LO = 1'b0, S_HI = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [HALF_W-1:0]   lo_q, lo_d;
   logic [2*HALF_W-1:0] data_d;
   logic                valid_d, partial_d;
   logic [CNT_W-1:0]    count_d;
   logic                slot_free, in_fire, out_fire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_LO;
         lo_q        <= '0;
         out_data    <= '0;
         out_valid   <= 1'b0;
         out_partial <= 1'b0;
         vec_count   <= '0;
      end else begin
         state_q     <= state_d;
         lo_q        <= lo_d;
         out_data    <= data_d;
         out_valid   <= valid_d;
         out_partial <= partial_d;
         vec_count   <= count_d;
      end
   end

   // Next-state, handshake and output-register update; flush beats in_valid.
   always_comb begin
      state_d   = state_q;
      lo_d      = lo_q;
      data_d    = out_data;
      valid_d   = out_valid;
      partial_d = out_partial;
      count_d   = vec_count;

      slot_free = !out_valid || out_ready;
      out_fire  = out_valid && out_ready;
      in_ready  = (state_q == S_LO) ? !flush : (!flush && slot_free);
      in_fire   = in_valid && in_ready;

      if (out_fire) begin
         valid_d   = 1'b0;
         partial_d = 1'b0;
         count_d   = vec_count + CNT_W'(1);
      end

      unique case (state_q)
         S_LO: begin
            // Lower halves never touch the output register, so they stream under a stall.
            if (in_fire) begin
               lo_d    = in_data;
               state_d = S_HI;
            end
         end
         S_HI: begin
            if (flush && slot_free) begin
               data_d    = {HALF_W'(0), lo_q};
               valid_d   = 1'b1;
               partial_d = 1'b1;
               state_d   = S_LO;
            end else if (in_fire) begin
               data_d    = {in_data, lo_q};
               valid_d   = 1'b1;
               partial_d = 1'b0;
               state_d   = S_LO;
            end
         end
         default: state_d = S_LO;
      endcase
   end

endmodule

// File: tb/tb_half_vector_collector.sv
// Bench for half_vector_collector: directed and random steps checked against a
// queue-based scoreboard of the vectors the consumer should receive.
module tb_half_vector_collector;

   localparam int unsigned NU = 8;
   localparam int unsigned EW = 32;
   localparam int unsigned HW = EW * (NU / 2);
   localparam int unsigned OW = 2 * HW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [HW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic          flush;
   logic [OW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_partial;
   logic [15:0]   vec_count;

   half_vector_collector #(.NO_OF_UNITS(NU), .ELEMENT_WIDTH(EW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .flush(flush),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_partial(out_partial), .vec_count(vec_count)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // Scoreboard: expected vectors {partial, data} in delivery order.
   logic [OW:0]   exp_q[$];
   bit            pend;
   logic [HW-1:0] m_lo;
   logic [15:0]   m_cnt;

   task automatic chk(input string tag, input logic [OW:0] obs, input logic [OW:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [HW-1:0] rnd_half();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic model_clear();
      exp_q.delete();
      pend  = 1'b0;
      m_lo  = '0;
      m_cnt = '0;
   endtask

   // One clock: drive, check ready and any delivered vector, update the model, check state.
   task automatic cyc(input logic v, input logic [HW-1:0] d, input logic f, input logic r);
      bit sfree, exp_rdy, acc;
      @(negedge clk);
      in_valid = v; in_data = d; flush = f; out_ready = r;
      #1;
      sfree   = (exp_q.size() == 0) || r;
      exp_rdy = !f && (!pend || sfree);
      chk("in_ready", (OW+1)'(in_ready), (OW+1)'(exp_rdy));
      acc = v && exp_rdy;
      if (exp_q.size() != 0 && r) begin
         chk("deliver", {out_partial, out_data}, exp_q[0]);
         void'(exp_q.pop_front());
         m_cnt = m_cnt + 16'd1;
      end
      if (!pend) begin
         if (acc) begin pend = 1'b1; m_lo = d; end
      end else if (f && sfree) begin
         exp_q.push_back({1'b1, HW'(0), m_lo});
         pend = 1'b0;
      end else if (acc) begin
         exp_q.push_back({1'b0, d, m_lo});
         pend = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("vec_count", (OW+1)'(vec_count), (OW+1)'(m_cnt));
      chk("out_valid", (OW+1)'(out_valid), (OW+1)'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("held_vector", {out_partial, out_data}, exp_q[0]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
      #1;
      chk("rst_out_valid", (OW+1)'(out_valid), '0);
      chk("rst_out_partial", (OW+1)'(out_partial), '0);
      chk("rst_out_data", (OW+1)'(out_data), '0);
      chk("rst_vec_count", (OW+1)'(vec_count), '0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", (OW+1)'(in_ready), (OW+1)'(1));
   endtask

   initial begin
      logic [HW-1:0] a, b, x;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
      model_clear();
      do_reset();

      // Basic pairing
      a = {32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hAAAA_AAAA};
      b = {32'hBBBB_BBBB, 32'hBBBB_BBBB, 32'hBBBB_BBBB, 32'hBBBB_BBBB};
      cyc(1'b1, a, 1'b0, 1'b1);
      chk("basic_no_early_valid", (OW+1)'(out_valid), '0);
      cyc(1'b1, b, 1'b0, 1'b1);
      chk("basic_pair", {out_valid, out_data}, {1'b1, b, a});
      chk("basic_partial", (OW+1)'(out_partial), '0);
      cyc(1'b0, '0, 1'b0, 1'b1);
      chk("basic_count", (OW+1)'(vec_count), (OW+1)'(1));

      // Streaming 20 halves back-to-back
      for (int i = 0; i < 20; i++) cyc(1'b1, rnd_half(), 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b1);
      chk("stream_count", (OW+1)'(vec_count), (OW+1)'(11));

      // Backpressure
      cyc(1'b1, rnd_half(), 1'b0, 1'b1);
      cyc(1'b1, rnd_half(), 1'b0, 1'b0);
      cyc(1'b1, rnd_half(), 1'b0, 1'b0);
      cyc(1'b1, rnd_half(), 1'b0, 1'b0);
      chk("bp_stall_ready", (OW+1)'(in_ready), '0);
      x = rnd_half();
      cyc(1'b1, x, 1'b0, 1'b1);
      chk("bp_second_upper", (OW+1)'(out_data[OW-1:HW]), (OW+1)'(x));
      cyc(1'b0, '0, 1'b0, 1'b1);

      // Flush of a lone lower half, then flush while idle
      cyc(1'b1, HW'(128'h1234), 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b1);
      chk("flush_partial", {out_partial, out_data}, {1'b1, HW'(0), HW'(128'h1234)});
      for (int i = 0; i < 3; i++) cyc(1'b1, rnd_half(), 1'b1, 1'b1);
      chk("flush_lo_no_out", (OW+1)'(out_valid), '0);

      // Flush and in_valid together in S_HI
      a = rnd_half();
      cyc(1'b1, a, 1'b0, 1'b1);
      cyc(1'b1, rnd_half(), 1'b1, 1'b1);
      chk("flush_wins", {out_partial, out_data}, {1'b1, HW'(0), a});
      // Flush held through a stall
      cyc(1'b1, rnd_half(), 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b1);

      // Random traffic
      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 3) != 0), rnd_half(),
             1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) != 0));
      for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b1);

      // Reset mid-pair discards the held lower half
      cyc(1'b1, rnd_half(), 1'b0, 1'b1);
      do_reset();
      a = rnd_half(); b = rnd_half();
      cyc(1'b1, a, 1'b0, 1'b1);
      cyc(1'b1, b, 1'b0, 1'b1);
      chk("fresh_pair", {out_partial, out_data}, {1'b0, b, a});
      cyc(1'b0, '0, 1'b0, 1'b1);

      // vec_count wrap from 0xFFFF
      @(negedge clk);
      force dut.vec_count = 16'hFFFF;
      #1;
      release dut.vec_count;
      m_cnt = 16'hFFFF;
      #1;
      chk("preload", (OW+1)'(vec_count), (OW+1)'(16'hFFFF));
      cyc(1'b1, rnd_half(), 1'b0, 1'b1);
      cyc(1'b1, rnd_half(), 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b1);
      chk("wrap", (OW+1)'(vec_count), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
